// File: rtl/inst_fifo_pkg.sv
// Shared definitions for the instruction FIFO: default depth, pointer width,
// the stored entry layout and a small slot-counting helper.
package inst_fifo_pkg;

    localparam int INST_FIFO_DEPTH = 16;
    localparam int INST_FIFO_PTR_W = $clog2(INST_FIFO_DEPTH);

    // One fetched instruction together with its program counter.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } inst_entry_t;

    // Number of active slots for a paired enable where slot1 implies slot0.
    function automatic logic [1:0] slot_count(input logic en0, input logic en1);
        logic [1:0] n;
        n = 2'd0;
        if (en0) begin
            n = en1 ? 2'd2 : 2'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/inst_fifo_ram.sv
// Entry storage for the instruction FIFO: two write ports, two combinational
// read ports, no reset (contents are only meaningful under the count).
module inst_fifo_ram
    import inst_fifo_pkg::*;
#(
    parameter int DEPTH = INST_FIFO_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en0,
    input  logic [PTR_W-1:0]  wr_addr0,
    input  inst_entry_t       wr_data0,
    input  logic              wr_en1,
    input  logic [PTR_W-1:0]  wr_addr1,
    input  inst_entry_t       wr_data1,
    input  logic [PTR_W-1:0]  rd_addr0,
    output inst_entry_t       rd_data0,
    input  logic [PTR_W-1:0]  rd_addr1,
    output inst_entry_t       rd_data1
);

    inst_entry_t mem [DEPTH];

    // Both write ports update storage on the same edge; addresses never collide
    // because slot1 always targets the entry after slot0.
    always_ff @(posedge clk) begin
        if (wr_en0) begin
            mem[wr_addr0] <= wr_data0;
        end
        if (wr_en1) begin
            mem[wr_addr1] <= wr_data1;
        end
    end

    assign rd_data0 = mem[rd_addr0];
    assign rd_data1 = mem[rd_addr1];

endmodule

// File: rtl/inst_fifo.sv
// Dual-issue instruction FIFO between fetch and decode. Up to two entries are
// written and up to two popped per cycle; head and head+1 are presented
// combinationally. A flush discards the contents.
// Optional build macro INST_FIFO_DS_KEEP_EN: a flush with flush_keep_ds keeps
// the first entry surviving this cycle's pops (the branch delay slot).
// DEPTH must be a power of two and at least 4.
module inst_fifo
    import inst_fifo_pkg::*;
#(
    parameter int DEPTH = INST_FIFO_DEPTH
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        flush_keep_ds,
    input  logic        write_en0,
    input  logic        write_en1,
    input  logic [31:0] write_pc0,
    input  logic [31:0] write_inst0,
    input  logic [31:0] write_pc1,
    input  logic [31:0] write_inst1,
    input  logic        read_en0,
    input  logic        read_en1,
    output logic [31:0] read_pc0,
    output logic [31:0] read_inst0,
    output logic [31:0] read_pc1,
    output logic [31:0] read_inst1,
    output logic        fifo_empty,
    output logic        fifo_one,
    output logic        fifo_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] FULL_THRESH = CNT_W'(DEPTH - 2);

    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             empty_reg, one_reg, full_reg;

    logic             wr_slot0, wr_slot1;
    logic [1:0]       wr_num;
    logic [1:0]       pop_num;

    inst_entry_t      wr_data0, wr_data1;
    inst_entry_t      rd_data [2];
    inst_entry_t      head    [2];
    logic [PTR_W-1:0] rd_addr [2];
    logic             rd_valid[2];

    // Writes are all-or-nothing on the registered full flag and are dropped
    // whenever the queue is being cleared.
    assign wr_slot0 = write_en0 & ~full_reg & ~flush & ~rst;
    assign wr_slot1 = wr_slot0 & write_en1;
    assign wr_num   = slot_count(wr_slot0, wr_slot1);

    assign wr_data0 = '{pc: write_pc0, inst: write_inst0};
    assign wr_data1 = '{pc: write_pc1, inst: write_inst1};

    // Pops are limited by the pre-edge occupancy; a second pop needs two entries.
    always_comb begin
        pop_num = 2'd0;
        if (read_en0 && count_reg != '0) begin
            pop_num = (read_en1 && count_reg > CNT_ONE) ? 2'd2 : 2'd1;
        end
    end

`ifdef INST_FIFO_DS_KEEP_EN
    logic [PTR_W-1:0] survivor_ptr;
    logic             survivor_valid;

    // The delay-slot candidate is the first entry not consumed this cycle.
    assign survivor_ptr   = rd_ptr_reg + PTR_W'(pop_num);
    assign survivor_valid = count_reg > CNT_W'(pop_num);
`else
    logic unused_flush_keep_ds;
    assign unused_flush_keep_ds = flush_keep_ds;
`endif

    // Next-state pointers and count; flush overrides normal read/write traffic.
    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        if (flush) begin
`ifdef INST_FIFO_DS_KEEP_EN
            if (flush_keep_ds && survivor_valid) begin
                rd_ptr_next = survivor_ptr;
                wr_ptr_next = survivor_ptr + PTR_W'(1);
                count_next  = CNT_ONE;
            end else begin
                rd_ptr_next = wr_ptr_reg;
                count_next  = '0;
            end
`else
            rd_ptr_next = wr_ptr_reg;
            count_next  = '0;
`endif
        end else begin
            rd_ptr_next = rd_ptr_reg + PTR_W'(pop_num);
            wr_ptr_next = wr_ptr_reg + PTR_W'(wr_num);
            count_next  = count_reg + CNT_W'(wr_num) - CNT_W'(pop_num);
        end
    end

    // State registers; status flags are registered from the next count.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            empty_reg  <= 1'b1;
            one_reg    <= 1'b0;
            full_reg   <= 1'b0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
            empty_reg  <= (count_next == '0);
            one_reg    <= (count_next == CNT_ONE);
            full_reg   <= (count_next > FULL_THRESH);
        end
    end

    // Head and head+1 read ports, each zeroed when that entry is not occupied.
    for (genvar gi = 0; gi < 2; gi++) begin : g_head
        assign rd_addr[gi]  = rd_ptr_reg + PTR_W'(gi);
        assign rd_valid[gi] = count_reg > CNT_W'(gi);
        assign head[gi]     = rd_valid[gi] ? rd_data[gi] : '0;
    end

    inst_fifo_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk      (clk),
        .wr_en0   (wr_slot0),
        .wr_addr0 (wr_ptr_reg),
        .wr_data0 (wr_data0),
        .wr_en1   (wr_slot1),
        .wr_addr1 (wr_ptr_reg + PTR_W'(1)),
        .wr_data1 (wr_data1),
        .rd_addr0 (rd_addr[0]),
        .rd_data0 (rd_data[0]),
        .rd_addr1 (rd_addr[1]),
        .rd_data1 (rd_data[1])
    );

    assign read_pc0   = head[0].pc;
    assign read_inst0 = head[0].inst;
    assign read_pc1   = head[1].pc;
    assign read_inst1 = head[1].inst;

    assign fifo_empty = empty_reg;
    assign fifo_one   = one_reg;
    assign fifo_full  = full_reg;

endmodule

// File: tb/tb_inst_fifo.sv
// Self-checking bench for inst_fifo: directed scenarios plus randomized traffic
// compared each cycle against a queue-based model of the FIFO rules.
module tb_inst_fifo;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0, flush = 1'b0, flush_keep_ds = 1'b0;
    logic        write_en0 = 1'b0, write_en1 = 1'b0;
    logic [31:0] write_pc0 = '0, write_inst0 = '0, write_pc1 = '0, write_inst1 = '0;
    logic        read_en0 = 1'b0, read_en1 = 1'b0;
    logic [31:0] read_pc0, read_inst0, read_pc1, read_inst1;
    logic        fifo_empty, fifo_one, fifo_full;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] q[$];   // model contents, {pc, inst}, head at index 0

    inst_fifo #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .flush_keep_ds(flush_keep_ds),
        .write_en0(write_en0), .write_en1(write_en1),
        .write_pc0(write_pc0), .write_inst0(write_inst0),
        .write_pc1(write_pc1), .write_inst1(write_inst1),
        .read_en0(read_en0), .read_en1(read_en1),
        .read_pc0(read_pc0), .read_inst0(read_inst0),
        .read_pc1(read_pc1), .read_inst1(read_inst1),
        .fifo_empty(fifo_empty), .fifo_one(fifo_one), .fifo_full(fifo_full)
    );

    always #5 clk = ~clk;

    wire [130:0] dut_vec = {fifo_empty, fifo_one, fifo_full,
                            read_pc0, read_inst0, read_pc1, read_inst1};

    function automatic logic [130:0] exp_vec();
        logic [63:0] h0, h1;
        h0 = (q.size() >= 1) ? q[0] : 64'd0;
        h1 = (q.size() >= 2) ? q[1] : 64'd0;
        return {q.size() == 0, q.size() == 1, q.size() > DEPTH - 2, h0, h1};
    endfunction

    // Apply one cycle of stimulus, advance the model, sample #1 after the edge.
    task automatic drive_cycle(input logic r, input logic f, input logic k,
                               input logic we0, input logic we1,
                               input logic [31:0] pc0, input logic [31:0] in0,
                               input logic [31:0] pc1, input logic [31:0] in1,
                               input logic re0, input logic re1);
        logic [63:0] nq[$];
        logic [63:0] ent;
        int pops;
        logic keep;
        rst = r; flush = f; flush_keep_ds = k;
        write_en0 = we0; write_en1 = we0 & we1;
        write_pc0 = pc0; write_inst0 = in0; write_pc1 = pc1; write_inst1 = in1;
        read_en0 = re0; read_en1 = re0 & re1;
        nq = q;
        pops = (re0 && q.size() >= 1) ? ((re1 && q.size() >= 2) ? 2 : 1) : 0;
        if (r) begin
            nq.delete();
        end else if (f) begin
            keep = 1'b0;
`ifdef INST_FIFO_DS_KEEP_EN
            keep = k;
`endif
            if (keep && q.size() > pops) begin
                ent = q[pops];
                nq.delete();
                nq.push_back(ent);
            end else begin
                nq.delete();
            end
        end else begin
            for (int i = 0; i < pops; i++) void'(nq.pop_front());
            if (!(q.size() > DEPTH - 2) && we0) begin
                nq.push_back({pc0, in0});
                if (we1) nq.push_back({pc1, in1});
            end
        end
        @(posedge clk);
        #1;
        q = nq;
        rst = 0; flush = 0; flush_keep_ds = 0;
        write_en0 = 0; write_en1 = 0; read_en0 = 0; read_en1 = 0;
    endtask

    task automatic test_reset();
        logic [130:0] e;
        drive_cycle(1, 0, 0, 1, 1, $urandom, $urandom, $urandom, $urandom, 1, 1);
        e = exp_vec();
        n_checks++;
        if (dut_vec !== e) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", dut_vec, e);
        end
        $display("test_reset: empty=%0b one=%0b full=%0b", fifo_empty, fifo_one, fifo_full);
    endtask

    task automatic test_dual_write();
        logic [130:0] e;
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 1, 1, 32'hBFC00000, 32'h11111111, 32'hBFC00004, 32'h22222222, 0, 0);
        n_checks++;
        if ({fifo_empty, fifo_one, read_pc0, read_pc1} !== {1'b0, 1'b0, 32'hBFC00000, 32'hBFC00004}) begin
            n_fail++;
            $display("FAIL dual_write: got empty=%0b one=%0b pc0=%h pc1=%h expected 0 0 bfc00000 bfc00004",
                     fifo_empty, fifo_one, read_pc0, read_pc1);
        end
        e = exp_vec();
        n_checks++;
        if (dut_vec !== e) begin
            n_fail++;
            $display("FAIL dual_write_model: got %h expected %h", dut_vec, e);
        end
        $display("test_dual_write: pc0=%h pc1=%h", read_pc0, read_pc1);
    endtask

    task automatic test_fill_full();
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++)
            drive_cycle(0, 0, 0, 1, 1, 32'h1000 + 8 * i, $urandom, 32'h1004 + 8 * i, $urandom, 0, 0);
        n_checks++;
        if (fifo_full !== 1'b0) begin
            n_fail++;
            $display("FAIL full_at_14: got %0b expected 0", fifo_full);
        end
        drive_cycle(0, 0, 0, 1, 0, 32'h1038, $urandom, 0, 0, 0, 0);
        n_checks++;
        if (fifo_full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_at_15: got %0b expected 1", fifo_full);
        end
        drive_cycle(0, 0, 0, 1, 1, 32'hDEAD0000, $urandom, 32'hDEAD0004, $urandom, 0, 0);
        n_checks++;
        if (dut.count_reg !== 5'd15 || fifo_full !== 1'b1) begin
            n_fail++;
            $display("FAIL full_drop: got count=%0d full=%0b expected count=15 full=1", dut.count_reg, fifo_full);
        end
        // Drain and verify order, no dropped-write data must appear.
        for (int i = 0; i < 8; i++) begin
            logic [130:0] e;
            drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
            e = exp_vec();
            n_checks++;
            if (dut_vec !== e) begin
                n_fail++;
                $display("FAIL full_drain: got %h expected %h", dut_vec, e);
            end
        end
        $display("test_fill_full: empty=%0b after drain", fifo_empty);
    endtask

    task automatic test_single_pop();
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 1, 0, 32'h4000, 32'h4444, 0, 0, 0, 0);
        n_checks++;
        if ({fifo_one, read_pc1} !== {1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL one_entry: got one=%0b pc1=%h expected 1 00000000", fifo_one, read_pc1);
        end
        drive_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        n_checks++;
        if ({fifo_empty, fifo_one, read_pc0} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL single_pop: got empty=%0b one=%0b pc0=%h expected 1 0 00000000",
                     fifo_empty, fifo_one, read_pc0);
        end
        $display("test_single_pop: empty=%0b", fifo_empty);
    endtask

    task automatic test_wrap();
        int k;
        k = 0;
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 1, 0, 32'h3000 + 4 * k, k, 0, 0, 0, 0); k++;
        for (int i = 0; i < 15; i++) begin
            drive_cycle(0, 0, 0, 1, 0, 32'h3000 + 4 * k, k, 0, 0, 1, 0); k++;
        end
        drive_cycle(0, 0, 0, 1, 0, 32'h3000 + 4 * k, k, 0, 0, 0, 0); k++;
        n_checks++;
        if (dut.rd_ptr_reg !== 4'd15) begin
            n_fail++;
            $display("FAIL wrap_setup: got rd_ptr=%0d expected 15", dut.rd_ptr_reg);
        end
        drive_cycle(0, 0, 0, 1, 1, 32'h3000 + 4 * k, k, 32'h3004 + 4 * k, k + 1, 1, 1);
        n_checks++;
        if ({fifo_empty, fifo_one, read_pc0, read_pc1, dut.rd_ptr_reg} !==
            {1'b0, 1'b0, 32'h3044, 32'h3048, 4'd1}) begin
            n_fail++;
            $display("FAIL wrap: got empty=%0b one=%0b pc0=%h pc1=%h rd=%0d expected 0 0 3044 3048 1",
                     fifo_empty, fifo_one, read_pc0, read_pc1, dut.rd_ptr_reg);
        end
        $display("test_wrap: pc0=%h pc1=%h", read_pc0, read_pc1);
    endtask

    task automatic test_flush_keep();
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 1, 1, 32'h2004, 1, 32'h2008, 2, 0, 0);
        drive_cycle(0, 0, 0, 1, 1, 32'h200C, 3, 32'h2010, 4, 0, 0);
        drive_cycle(0, 0, 0, 1, 0, 32'h2014, 5, 0, 0, 0, 0);
        drive_cycle(0, 1, 1, 1, 1, 32'hEEEE0000, 6, 32'hEEEE0004, 7, 1, 0);
        n_checks++;
`ifdef INST_FIFO_DS_KEEP_EN
        if ({fifo_empty, fifo_one, read_pc0, read_inst0, read_pc1} !==
            {1'b0, 1'b1, 32'h2008, 32'd2, 32'h0}) begin
            n_fail++;
            $display("FAIL flush_keep: got empty=%0b one=%0b pc0=%h inst0=%h pc1=%h expected 0 1 2008 2 0",
                     fifo_empty, fifo_one, read_pc0, read_inst0, read_pc1);
        end
`else
        if ({fifo_empty, fifo_one, read_pc0} !== {1'b1, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL flush_clear: got empty=%0b one=%0b pc0=%h expected 1 0 0",
                     fifo_empty, fifo_one, read_pc0);
        end
`endif
        $display("test_flush_keep: empty=%0b one=%0b pc0=%h", fifo_empty, fifo_one, read_pc0);
    endtask

    task automatic test_rst_priority();
        logic [130:0] rv;
        rv = '0;
        rv[130] = 1'b1;
        drive_cycle(0, 0, 0, 1, 1, 32'h5000, 1, 32'h5004, 2, 0, 0);
        drive_cycle(0, 0, 0, 1, 1, 32'h5008, 3, 32'h500C, 4, 0, 0);
        drive_cycle(1, 1, 1, 1, 1, 32'h5010, 5, 32'h5014, 6, 1, 1);
        n_checks++;
        if (dut_vec !== rv) begin
            n_fail++;
            $display("FAIL rst_priority: got %h expected %h", dut_vec, rv);
        end
        $display("test_rst_priority: empty=%0b", fifo_empty);
    endtask

    task automatic test_random();
        int wr_pct, rd_pct;
        int local_fail;
        local_fail = 0;
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int c = 0; c < 600; c++) begin
            logic [130:0] e;
            wr_pct = (c % 200 < 100) ? 80 : 35;
            rd_pct = (c % 200 < 100) ? 30 : 80;
            drive_cycle($urandom_range(99) < 1, $urandom_range(99) < 4, $urandom_range(1),
                        $urandom_range(99) < wr_pct, $urandom_range(1),
                        $urandom, $urandom, $urandom, $urandom,
                        $urandom_range(99) < rd_pct, $urandom_range(1));
            e = exp_vec();
            n_checks++;
            if (dut_vec !== e) begin
                n_fail++;
                local_fail++;
                $display("FAIL random_cycle_%0d: got %h expected %h", c, dut_vec, e);
            end
        end
        $display("test_random: 600 cycles, %0d mismatched", local_fail);
    endtask

    initial begin
        test_reset();
        test_dual_write();
        test_fill_full();
        test_single_pop();
        test_wrap();
        test_flush_keep();
        test_rst_priority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
